// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory handshake, redirect/stall control
// from the pipeline, and the instruction presented to decode.
interface fetch_if;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_instr;

    // Fetch unit side.
    modport master (
        input  imem_ready, imem_rdata, redirect, redirect_pc, stall,
        output imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    // Memory / pipeline side.
    modport slave (
        output imem_ready, imem_rdata, redirect, redirect_pc, stall,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register plus a 2-entry {pc, instr} buffer that
// decouples memory wait states from decode stalls. Redirects flush everything.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);
    localparam logic [15:0] PcInit = RESET_PC & 16'hFFFE;

    logic [15:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] ent0_q, ent0_d;  // head entry {pc, instr}
    logic [31:0] ent1_q, ent1_d;
    logic        push, pop;
    logic [1:0]  slot;
    logic        req;

    // Request gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        req  = rst_n && (count_q < 2'd2) && !bus.redirect;
        push = req && bus.imem_ready;
        pop  = (count_q != 2'd0) && !bus.stall && !bus.redirect;
    end

    // Next-state: redirect flushes; otherwise pop shifts head, push fills the first free slot.
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        slot    = count_q - {1'b0, pop};
        if (bus.redirect) begin
            count_d = 2'd0;
            pc_d    = {bus.redirect_pc[15:1], 1'b0};
        end else begin
            if (pop) begin
                ent0_d = ent1_q;
            end
            if (push) begin
                pc_d = pc_q + 16'd2;
                if (slot == 2'd0) begin
                    ent0_d = {pc_q, bus.imem_rdata};
                end else begin
                    ent1_d = {pc_q, bus.imem_rdata};
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PcInit;
            count_q <= 2'd0;
            ent0_q  <= 32'h0;
            ent1_q  <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    // Outputs present the buffer head, or a zero bubble when empty.
    always_comb begin
        bus.imem_req  = req;
        bus.imem_addr = pc_q[11:0];
        bus.if_valid  = (count_q != 2'd0);
        bus.if_pc     = (count_q != 2'd0) ? ent0_q[31:16] : 16'h0000;
        bus.if_instr  = (count_q != 2'd0) ? ent0_q[15:0] : 16'h0000;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked against
// a queue-based model of the fetch buffer.
module tb_fetch_unit;
    localparam logic [15:0] MainReset = 16'h0001;  // bit 0 must be dropped
    localparam logic [15:0] WrapReset = 16'hFFFC;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fetch_if bus ();
    fetch_if bus_w ();

    fetch_unit #(.RESET_PC(MainReset)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    fetch_unit #(.RESET_PC(WrapReset)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_w));

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        return {~a[3:0], a};
    endfunction

    assign bus.imem_rdata   = mem_word(bus.imem_addr);
    assign bus_w.imem_rdata = mem_word(bus_w.imem_addr);

    // Model state: buffered {pc, instr} pairs and the next fetch PC.
    logic [31:0] mq[$];
    logic [15:0] mpc;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rdy, input logic stl, input logic rd,
                        input logic [15:0] rpc);
        logic        e_req, e_valid;
        logic [15:0] e_pc, e_instr;
        @(negedge clk);
        rst_n           = rst;
        bus.imem_ready  = rdy;
        bus.stall       = stl;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        #1;
        e_req   = rst && (mq.size() < 2) && !rd;
        e_valid = (mq.size() != 0);
        e_pc    = e_valid ? mq[0][31:16] : 16'h0000;
        e_instr = e_valid ? mq[0][15:0] : 16'h0000;
        chk("imem_req", {15'h0, bus.imem_req}, {15'h0, e_req});
        chk("imem_addr", {4'h0, bus.imem_addr}, {4'h0, mpc[11:0]});
        chk("if_valid", {15'h0, bus.if_valid}, {15'h0, e_valid});
        chk("if_pc", bus.if_pc, e_pc);
        chk("if_instr", bus.if_instr, e_instr);
        if (rst) begin
            if (rd) begin
                mq.delete();
                mpc = {rpc[15:1], 1'b0};
            end else begin
                if (e_valid && !stl) void'(mq.pop_front());
                if (e_req && rdy) begin
                    mq.push_back({mpc, mem_word(mpc[11:0])});
                    mpc = mpc + 16'd2;
                end
            end
        end
    endtask

    task automatic run(input logic rdy, input logic stl, input logic rd, input logic [15:0] rpc);
        step(1'b1, rdy, stl, rd, rpc);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.imem_ready    = 1'b0;
        bus.stall         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = 16'h0;
        bus_w.imem_ready  = 1'b1;
        bus_w.stall       = 1'b0;
        bus_w.redirect    = 1'b0;
        bus_w.redirect_pc = 16'h0;
        mpc               = MainReset & 16'hFFFE;
        #12;
        chk("rst_req", {15'h0, bus.imem_req}, 16'h0);
        chk("rst_valid", {15'h0, bus.if_valid}, 16'h0);
        chk("rst_addr", {4'h0, bus.imem_addr}, 16'h0000);

        // Release and stream; wrap instance checked alongside.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("wrap_valid0", {15'h0, bus_w.if_valid}, 16'h0);
        chk("wrap_addr0", {4'h0, bus_w.imem_addr}, 16'h0FFC);
        run(1'b1, 1'b0, 1'b0, 16'h0);
        chk("wrap_pc1", bus_w.if_pc, 16'hFFFC);
        chk("wrap_addr1", {4'h0, bus_w.imem_addr}, 16'h0FFE);
        run(1'b1, 1'b0, 1'b0, 16'h0);
        chk("wrap_pc2", bus_w.if_pc, 16'hFFFE);
        chk("wrap_addr2", {4'h0, bus_w.imem_addr}, 16'h0000);
        run(1'b1, 1'b0, 1'b0, 16'h0);
        chk("wrap_pc3", bus_w.if_pc, 16'h0000);
        chk("stream_pc", bus.if_pc, 16'h0004);

        // Wait states: address must hold while ready is low.
        for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 1'b0, 16'h0);
        chk("wait_drained", {15'h0, bus.if_valid}, 16'h0);
        for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 1'b0, 16'h0);

        // Backpressure: buffer fills, requests stop.
        for (int i = 0; i < 5; i++) run(1'b1, 1'b1, 1'b0, 16'h0);
        chk("stall_req", {15'h0, bus.imem_req}, 16'h0);
        for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 1'b0, 16'h0);

        // Redirect with a full buffer; target visible two cycles later.
        for (int i = 0; i < 3; i++) run(1'b1, 1'b1, 1'b0, 16'h0);
        run(1'b1, 1'b0, 1'b1, 16'h0041);
        run(1'b1, 1'b0, 1'b0, 16'h0);
        run(1'b1, 1'b0, 1'b0, 16'h0);
        chk("redir_pc", bus.if_pc, 16'h0040);

        // Back-to-back redirects: last wins.
        run(1'b1, 1'b0, 1'b1, 16'h0100);
        run(1'b1, 1'b0, 1'b1, 16'h0203);
        run(1'b1, 1'b0, 1'b0, 16'h0);
        run(1'b1, 1'b0, 1'b0, 16'h0);
        chk("redir2_pc", bus.if_pc, 16'h0202);

        // Async reset mid-cycle during a wait state with data buffered.
        run(1'b0, 1'b1, 1'b0, 16'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {15'h0, bus.imem_req}, 16'h0);
        chk("arst_valid", {15'h0, bus.if_valid}, 16'h0);
        chk("arst_pc", bus.if_pc, 16'h0);
        chk("arst_instr", bus.if_instr, 16'h0);
        chk("arst_addr", {4'h0, bus.imem_addr}, 16'h0000);
        mq.delete();
        mpc = MainReset & 16'hFFFE;
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("arst_first_req", {15'h0, bus.imem_req}, 16'h1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            run($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
